// File: rtl/fft_pkg.sv
// Shared constants, types and helpers for the 32-point MDC FFT datapath.
package fft_pkg;

  localparam int DEF_WIDTH = 9;
  localparam int FFT_N     = 32;
  localparam int HALF_N    = FFT_N / 2;

  typedef struct packed {
    logic signed [DEF_WIDTH-1:0] re;
    logic signed [DEF_WIDTH-1:0] im;
  } cplx_t;

  function automatic logic [3:0] rev4(input logic [3:0] k);
    return {k[0], k[1], k[2], k[3]};
  endfunction

endpackage

// File: rtl/reorder_bank.sv
// One 32-entry sample bank: two writes per cycle (a and a+16), async read.
module reorder_bank
  import fft_pkg::*;
#(
  parameter int W = 2 * DEF_WIDTH
) (
  input  logic         clk,
  input  logic         we,
  input  logic [3:0]   waddr,
  input  logic [W-1:0] wdata_lo,
  input  logic [W-1:0] wdata_hi,
  input  logic [4:0]   raddr,
  output logic [W-1:0] rdata
);

  logic [W-1:0] mem_q [FFT_N];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[{1'b0, waddr}] <= wdata_lo;
      mem_q[{1'b1, waddr}] <= wdata_hi;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/fft_out_reorder.sv
// Ping-pong reorder buffer: bit-reversed two-lane FFT beats in, natural-order
// single samples out.
module fft_out_reorder
  import fft_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int N     = FFT_N
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sof,
  input  logic [WIDTH-1:0] in_up_re,
  input  logic [WIDTH-1:0] in_up_im,
  input  logic [WIDTH-1:0] in_l_re,
  input  logic [WIDTH-1:0] in_l_im,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_re,
  output logic [WIDTH-1:0] out_im,
  output logic [4:0]       out_idx,
  output logic             out_sof,
  output logic             out_eof,
  output logic [7:0]       drop_cnt
);

  localparam logic [3:0] LAST_K   = 4'(N / 2 - 1);
  localparam logic [4:0] LAST_IDX = 5'(N - 1);

  logic [1:0]       full_q, full_d;
  logic             wbank_q, wbank_d;
  logic             rbank_q, rbank_d;
  logic [3:0]       k_q, k_d;
  logic [4:0]       ridx_q, ridx_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_re_q, out_re_d;
  logic [WIDTH-1:0] out_im_q, out_im_d;
  logic [4:0]       out_idx_q, out_idx_d;
  logic             out_sof_q, out_sof_d;
  logic             out_eof_q, out_eof_d;
  logic [7:0]       drop_cnt_q, drop_cnt_d;

  logic             accept, wr_en, load;
  logic [3:0]       wk;
  logic [2*WIDTH-1:0] rdata0, rdata1, rd_word;

  // Handshakes: a transfer happens on a rising edge where valid & ready are
  // both high; valid never waits on ready, and in_ready depends only on flops.
  assign in_ready = ~full_q[wbank_q];
  assign accept   = in_valid & in_ready;
  assign wk       = in_sof ? 4'd0 : k_q;
  // Beats at k==0 without a start-of-frame are dropped on the floor.
  assign wr_en    = accept & (in_sof | (k_q != 4'd0));
  assign load     = full_q[rbank_q] & (~out_valid_q | out_ready);
  assign rd_word  = rbank_q ? rdata1 : rdata0;

  reorder_bank #(.W(2 * WIDTH)) u_bank0 (
    .clk      (clk),
    .we       (wr_en & ~wbank_q),
    .waddr    (rev4(wk)),
    .wdata_lo ({in_up_re, in_up_im}),
    .wdata_hi ({in_l_re, in_l_im}),
    .raddr    (ridx_q),
    .rdata    (rdata0)
  );

  reorder_bank #(.W(2 * WIDTH)) u_bank1 (
    .clk      (clk),
    .we       (wr_en & wbank_q),
    .waddr    (rev4(wk)),
    .wdata_lo ({in_up_re, in_up_im}),
    .wdata_hi ({in_l_re, in_l_im}),
    .raddr    (ridx_q),
    .rdata    (rdata1)
  );

  always_comb begin
    full_d      = full_q;
    wbank_d     = wbank_q;
    rbank_d     = rbank_q;
    k_d         = k_q;
    ridx_d      = ridx_q;
    out_valid_d = out_valid_q;
    out_re_d    = out_re_q;
    out_im_d    = out_im_q;
    out_idx_d   = out_idx_q;
    out_sof_d   = out_sof_q;
    out_eof_d   = out_eof_q;
    drop_cnt_d  = drop_cnt_q;

    if (load) begin
      out_valid_d = 1'b1;
      out_re_d    = rd_word[2*WIDTH-1:WIDTH];
      out_im_d    = rd_word[WIDTH-1:0];
      out_idx_d   = ridx_q;
      out_sof_d   = (ridx_q == 5'd0);
      out_eof_d   = (ridx_q == LAST_IDX);
      if (ridx_q == LAST_IDX) begin
        full_d[rbank_q] = 1'b0;
        rbank_d         = ~rbank_q;
        ridx_d          = 5'd0;
      end else begin
        ridx_d = ridx_q + 5'd1;
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
      out_sof_d   = 1'b0;
      out_eof_d   = 1'b0;
    end

    // A new start-of-frame while mid-frame aborts the partial frame.
    if (accept & in_sof & (k_q != 4'd0) & (drop_cnt_q != 8'hFF)) begin
      drop_cnt_d = drop_cnt_q + 8'd1;
    end

    if (wr_en) begin
      if (wk == LAST_K) begin
        full_d[wbank_q] = 1'b1;
        wbank_d         = ~wbank_q;
        k_d             = 4'd0;
      end else begin
        k_d = wk + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q      <= 2'b00;
      wbank_q     <= 1'b0;
      rbank_q     <= 1'b0;
      k_q         <= 4'd0;
      ridx_q      <= 5'd0;
      out_valid_q <= 1'b0;
      out_re_q    <= '0;
      out_im_q    <= '0;
      out_idx_q   <= 5'd0;
      out_sof_q   <= 1'b0;
      out_eof_q   <= 1'b0;
      drop_cnt_q  <= 8'd0;
    end else begin
      full_q      <= full_d;
      wbank_q     <= wbank_d;
      rbank_q     <= rbank_d;
      k_q         <= k_d;
      ridx_q      <= ridx_d;
      out_valid_q <= out_valid_d;
      out_re_q    <= out_re_d;
      out_im_q    <= out_im_d;
      out_idx_q   <= out_idx_d;
      out_sof_q   <= out_sof_d;
      out_eof_q   <= out_eof_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_re    = out_re_q;
  assign out_im    = out_im_q;
  assign out_idx   = out_idx_q;
  assign out_sof   = out_sof_q;
  assign out_eof   = out_eof_q;
  assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_fft_out_reorder.sv
// Directed bench for fft_out_reorder: bit-reversed frames in, natural order out.
module tb_fft_out_reorder;

  localparam int W  = 9;
  localparam int EW = 5 + 2 * W;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready, in_sof;
  logic [W-1:0] in_up_re, in_up_im, in_l_re, in_l_im;
  logic         out_valid, out_ready;
  logic [W-1:0] out_re, out_im;
  logic [4:0]   out_idx;
  logic         out_sof, out_eof;
  logic [7:0]   drop_cnt;

  logic [EW-1:0] exp_q[$];
  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  int last_acc_cyc = 0;
  int first_valid_cyc = 0;
  int stall_cycles = 0;

  fft_out_reorder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sof    (in_sof),
    .in_up_re  (in_up_re),
    .in_up_im  (in_up_im),
    .in_l_re   (in_l_re),
    .in_l_im   (in_l_im),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_re    (out_re),
    .out_im    (out_im),
    .out_idx   (out_idx),
    .out_sof   (out_sof),
    .out_eof   (out_eof),
    .drop_cnt  (drop_cnt)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [3:0] brev(input logic [3:0] k);
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = k[3-i];
    return r;
  endfunction

  function automatic logic [W-1:0] re_of(input int base, input int j);
    return W'(base + j);
  endfunction

  function automatic logic [W-1:0] im_of(input int base, input int j);
    return W'(-(base + j));
  endfunction

  task automatic push_frame(input int base);
    for (int j = 0; j < 32; j++) exp_q.push_back({5'(j), re_of(base, j), im_of(base, j)});
  endtask

  task automatic align();
    @(posedge clk);
    #1;
  endtask

  // driver: called just after a rising edge; returns just after the accepting edge
  task automatic drive_beat(input logic sof, input logic [W-1:0] ur, input logic [W-1:0] ui,
                            input logic [W-1:0] lr, input logic [W-1:0] li);
    in_valid = 1'b1;
    in_sof   = sof;
    in_up_re = ur;
    in_up_im = ui;
    in_l_re  = lr;
    in_l_im  = li;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        last_acc_cyc = cyc;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        return;
      end
      stall_cycles++;
      @(posedge clk);
      #1;
    end
    compared++;
    mismatched++;
    $display("FAIL drive_timeout: in_ready=%b after 300 cycles, want 1", in_ready);
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic drive_frame(input int base);
    logic [3:0] j;
    for (int k = 0; k < 16; k++) begin
      j = brev(4'(k));
      drive_beat(k == 0, re_of(base, int'(j)), im_of(base, int'(j)),
                 re_of(base, int'(j) + 16), im_of(base, int'(j) + 16));
    end
  endtask

  // scoreboard consumer: pops exp_q for every accepted output sample
  task automatic collect(input int n, input bit rand_ready, input bit need_contig, input string tag);
    int got = 0;
    int gaps = 0;
    int t = 0;
    bit seen = 0;
    bit stalled = 0;
    logic [EW+2:0] held = '0;
    logic [EW-1:0] e;
    logic [4:0] ei;
    first_valid_cyc = -1;
    while (got < n && t < 2000) begin
      @(posedge clk);
      #1;
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      t++;
      if (stalled) begin
        compared++;
        if ({out_valid, out_idx, out_re, out_im, out_sof, out_eof} !== held) begin
          mismatched++;
          $display("FAIL %s stall_hold: got %h, want %h", tag,
                   {out_valid, out_idx, out_re, out_im, out_sof, out_eof}, held);
        end
      end
      if (out_valid) begin
        if (!seen) first_valid_cyc = cyc;
        seen = 1;
        if (out_ready) begin
          stalled = 0;
          got++;
          compared++;
          if (exp_q.size() == 0) begin
            mismatched++;
            $display("FAIL %s unexpected_sample: got idx=%0d, want none", tag, out_idx);
          end else begin
            e  = exp_q.pop_front();
            ei = e[EW-1 -: 5];
            if ({out_idx, out_re, out_im} !== e || out_sof !== (ei == 5'd0) ||
                out_eof !== (ei == 5'd31)) begin
              mismatched++;
              $display("FAIL %s sample: got idx=%0d re=%0d im=%0d sof=%b eof=%b, want idx=%0d re=%0d im=%0d sof=%b eof=%b",
                       tag, out_idx, $signed(out_re), $signed(out_im), out_sof, out_eof,
                       ei, $signed(e[2*W-1:W]), $signed(e[W-1:0]), ei == 5'd0, ei == 5'd31);
            end
          end
        end else begin
          stalled = 1;
          held = {out_valid, out_idx, out_re, out_im, out_sof, out_eof};
        end
      end else begin
        stalled = 0;
        if (seen) gaps++;
      end
    end
    out_ready = 1'b1;
    if (got < n) begin
      compared++;
      mismatched++;
      $display("FAIL %s collect_timeout: got %0d samples, want %0d", tag, got, n);
    end
    if (need_contig) begin
      compared++;
      if (gaps != 0) begin
        mismatched++;
        $display("FAIL %s contiguous: got %0d bubbles, want 0", tag, gaps);
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    compared++;
    if ({out_valid, out_idx, out_re, out_im, out_sof, out_eof, drop_cnt, in_ready} !==
        {1'b0, 5'd0, 9'd0, 9'd0, 1'b0, 1'b0, 8'd0, 1'b1}) begin
      mismatched++;
      $display("FAIL reset_state: got valid=%b idx=%0d re=%0d im=%0d sof=%b eof=%b drop=%0d in_ready=%b, want all 0 with in_ready=1",
               out_valid, out_idx, out_re, out_im, out_sof, out_eof, drop_cnt, in_ready);
    end
  endtask

  task automatic test_single_frame();
    align();
    push_frame(0);
    fork
      drive_frame(0);
      collect(32, 1'b0, 1'b1, "single");
    join
    compared++;
    if (first_valid_cyc !== last_acc_cyc + 1) begin
      mismatched++;
      $display("FAIL single_latency: got first valid at cycle %0d, want %0d", first_valid_cyc, last_acc_cyc + 1);
    end
  endtask

  task automatic test_back_to_back();
    align();
    push_frame(32);
    push_frame(64);
    push_frame(96);
    fork
      begin
        stall_cycles = 0;
        drive_frame(32);
        drive_frame(64);
        compared++;
        if (stall_cycles != 0) begin
          mismatched++;
          $display("FAIL b2b_in_ready: got %0d not-ready cycles over 32 beats, want 0", stall_cycles);
        end
        drive_frame(96);
      end
      collect(96, 1'b0, 1'b1, "b2b");
    join
  endtask

  task automatic test_stall_full();
    align();
    out_ready = 1'b0;
    push_frame(128);
    push_frame(160);
    drive_frame(128);
    drive_frame(160);
    @(negedge clk);
    compared++;
    if (in_ready !== 1'b0) begin
      mismatched++;
      $display("FAIL full_in_ready: got %b, want 0", in_ready);
    end
    compared++;
    if ({out_valid, out_idx, out_sof, out_re} !== {1'b1, 5'd0, 1'b1, re_of(128, 0)}) begin
      mismatched++;
      $display("FAIL full_head: got valid=%b idx=%0d sof=%b re=%0d, want 1 0 1 128", out_valid, out_idx, out_sof, out_re);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_sof   = 1'b1;
    in_up_re = 9'd7;
    in_up_im = 9'd7;
    in_l_re  = 9'd7;
    in_l_im  = 9'd7;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      compared++;
      if (in_ready !== 1'b0) begin
        mismatched++;
        $display("FAIL beat33_ignored: got in_ready=%b, want 0", in_ready);
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    in_sof   = 1'b0;
    collect(64, 1'b0, 1'b1, "stall_drain");
    repeat (3) @(negedge clk);
    compared++;
    if (out_valid !== 1'b0 || exp_q.size() != 0 || in_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL stall_after: got valid=%b left=%0d in_ready=%b, want 0 0 1", out_valid, exp_q.size(), in_ready);
    end
  endtask

  task automatic test_random_ready();
    align();
    push_frame(10);
    push_frame(50);
    fork
      begin
        drive_frame(10);
        drive_frame(50);
      end
      collect(64, 1'b1, 1'b0, "random");
    join
  endtask

  task automatic test_abort();
    logic [3:0] j;
    align();
    drive_beat(1'b0, 9'd1, 9'd2, 9'd3, 9'd4);
    drive_beat(1'b0, 9'd5, 9'd6, 9'd7, 9'd8);
    for (int k = 0; k < 7; k++) begin
      j = brev(4'(k));
      drive_beat(k == 0, re_of(200, int'(j)), im_of(200, int'(j)),
                 re_of(200, int'(j) + 16), im_of(200, int'(j) + 16));
    end
    push_frame(90);
    fork
      drive_frame(90);
      collect(32, 1'b0, 1'b1, "abort");
    join
    compared++;
    if (drop_cnt !== 8'd1) begin
      mismatched++;
      $display("FAIL abort_drop_cnt: got %0d, want 1", drop_cnt);
    end
  endtask

  task automatic test_reset_mid_drain();
    bit hit = 0;
    align();
    out_ready = 1'b1;
    fork
      drive_frame(20);
      for (int t = 0; t < 300 && !hit; t++) begin
        @(negedge clk);
        if (out_valid && out_idx == 5'd12) hit = 1;
      end
    join
    if (!hit) begin
      compared++;
      mismatched++;
      $display("FAIL rst_reach_idx12: got idx=%0d, want 12", out_idx);
    end
    #2;
    rst_n = 1'b0;
    #1;
    compared++;
    if ({out_valid, out_idx, out_sof, out_eof, drop_cnt} !== {1'b0, 5'd0, 1'b0, 1'b0, 8'd0}) begin
      mismatched++;
      $display("FAIL rst_async: got valid=%b idx=%0d sof=%b eof=%b drop=%0d, want 0 0 0 0 0",
               out_valid, out_idx, out_sof, out_eof, drop_cnt);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    compared++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL rst_release: got in_ready=%b valid=%b, want 1 0", in_ready, out_valid);
    end
    align();
    push_frame(150);
    fork
      drive_frame(150);
      collect(32, 1'b0, 1'b1, "after_reset");
    join
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_sof    = 1'b0;
    in_up_re  = '0;
    in_up_im  = '0;
    in_l_re   = '0;
    in_l_im   = '0;
    out_ready = 1'b1;
    #23;
    rst_n = 1'b1;
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_stall_full();
    test_random_ready();
    test_abort();
    test_reset_mid_drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/fft_out_reorder.md
Name: fft_out_reorder

Overview:
Output reorder buffer for the 32-point MDC FFT. It consumes the two-lane (upper/lower) bit-reversed result stream from the last FFT stage. It emits one natural-order complex sample per cycle (bins 0..31) over a valid/ready handshake. Ping-pong buffering lets one frame be written while the previous frame drains.

Parameters:
WIDTH, 9, bit width of each real/imag component (signed two's complement)
N, 32, FFT points per frame (fixed; beats per frame = N/2 = 16)

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  upper/lower lane pair valid this cycle
in_ready  output  1  block can accept a beat this cycle
in_sof  input  1  first beat (k=0) of a frame, qualified by in_valid
in_up_re  input  WIDTH  upper lane real
in_up_im  input  WIDTH  upper lane imag
in_l_re  input  WIDTH  lower lane real
in_l_im  input  WIDTH  lower lane imag
out_valid  output  1  out_* holds a valid sample
out_ready  input  1  downstream accepts sample
out_re  output  WIDTH  sample real
out_im  output  WIDTH  sample imag
out_idx  output  5  natural bin index of current sample
out_sof  output  1  out_idx==0 with out_valid
out_eof  output  1  out_idx==31 with out_valid
drop_cnt  output  8  saturating count of aborted partial frames

Behaviour:
- Clock clk; reset rst_n is asynchronous and active-low. On reset: both banks empty; write bank=0, read bank=0, write beat k=0; read idx=0; out_valid=0, out_re/im=0, out_idx=0, out_sof=0, out_eof=0, drop_cnt=0. in_ready=1 after reset deassertion.
- Lane mapping, decided: at beat k (0..15), upper lane = X[rev4(k)], lower lane = X[16+rev4(k)]. rev4 reverses the 4-bit k.
- Write side: beat accepted when in_valid & in_ready. It stores upper at address rev4(k) and lower at rev4(k)+16 of the write bank, then increments k.
  - On accepting k=15, the write bank is marked full, write bank toggles, and k returns to 0.
- Write framing: beats are accepted only after an in_sof.
  - A beat with in_valid & in_ready & !in_sof while k==0 is discarded.
  - in_sof accepted while k!=0: the partial frame is aborted, drop_cnt increments (saturates at 255), and this beat is written as k=0.
- in_ready = 0 only when the current write bank is full (both banks full). Beats offered while in_ready=0 are ignored.
- Read side: the output register set (out_valid, out_re/im, out_idx, out_sof, out_eof) is registered. It is loaded when the read bank is full and (!out_valid or out_ready).
  - It loads the entry at read idx, then idx increments.
  - After loading idx 31, the read bank is marked empty, read bank toggles, and idx=0.
  - With no data to load and out_ready=1, out_valid clears.
- Output latency: a bank marked full at edge T gives out_valid=1 with out_idx=0 after edge T+1.
  - With out_ready held high, the 32 samples appear on consecutive cycles and out_idx runs 0..31.
  - Back-to-back frames stream with no gap between idx 31 and the next idx 0.
- Stall: with out_valid=1 and out_ready=0, all out_* hold unchanged.
- Simultaneous events: a bank may be freed by a read (idx 31 load) on the same edge the other bank becomes full. The freed state is visible to in_ready on the next cycle, so in_ready is registered-state based with no combinational path from out_ready.
- Data is stored and output unmodified: no scaling or rounding.
- Reset mid-operation discards all buffered data immediately. drop_cnt also returns to 0.

Decomposition:
- Shared package fft_pkg: WIDTH default, N=32, HALF_N=16, function rev4 (4-bit bit reversal), complex sample struct/typedef {re, im} of WIDTH.
- One sub-module, reorder_bank: a 32-entry × 2·WIDTH register file with two write ports (addresses a, a+16 written in one cycle) and one asynchronous read port. Instantiate it twice, once per bank; it has no reset on storage.

Test Plan:
- Single frame, sample value = bin index (re=j, im=-j), out_ready=1 → out_idx 0..31 on 32 consecutive cycles with re=0..31 and im=0..-31. out_sof on idx 0, out_eof on idx 31. First out_valid one cycle after beat 15 accepted.
- Three back-to-back frames (48 continuous beats), out_ready=1 → in_ready stays 1. 96 outputs contiguous with no bubble between frames.
- out_ready held 0 after frame 1 while two frames are offered → in_ready drops to 0 after the 32nd beat. Offered beat 33 is ignored. Releasing out_ready drains frame 1 then frame 2 intact.
- Random out_ready (50%) → every sample appears exactly once in order. out_* stable during each stall.
- in_sof at k=7 mid-frame → drop_cnt=1. The following 16-beat frame outputs correctly with no stale data from the aborted frame.
- rst_n pulsed low mid-drain at idx 12 (asynchronously, between edges) → out_valid=0 immediately. in_ready=1 after release. The next full frame outputs idx 0..31 correctly.
